// File: rtl/sweep_pkg.sv
// Shared types and helpers for the sweep pulse generator: FSM encoding,
// select width / step size derivation and the per-channel threshold rule.
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  // Bits needed to encode 0..steps, so the "always on" step is representable.
  function automatic int sel_width(input int steps);
    return $clog2(steps + 1);
  endfunction

  function automatic int step_size(input int period_width, input int steps);
    return (1 << period_width) / steps;
  endfunction

  function automatic int step_clamp(input int sel, input int steps);
    return (sel > steps) ? steps : sel;
  endfunction

  // The top step is pinned to the full period so it stays on even when
  // the period does not divide evenly by the number of steps.
  function automatic int threshold(input int sel, input int steps, input int period_width);
    int s;
    s = step_clamp(sel, steps);
    if (s == steps) return 1 << period_width;
    return s * step_size(period_width, steps);
  endfunction

endpackage

// File: rtl/sweep_pwm_driver_if.sv
// Control/observation bundle of sweep_pwm_driver: enable, update strobe,
// per-channel mask/select in; PWM pulses, period tick, busy and FSM state out.
interface sweep_pwm_driver_if #(
  parameter int WIDTH     = 4,
  parameter int SEL_WIDTH = 3
);
  import sweep_pkg::*;

  // set_i is a one-cycle strobe with no back-pressure: the block accepts
  // mask_i/select_i on every cycle set_i is high outside IDLE.
  logic                       en_i;
  logic                       set_i;
  logic [WIDTH-1:0]           mask_i;
  logic [SEL_WIDTH*WIDTH-1:0] select_i;
  logic [WIDTH-1:0]           pulse_o;
  logic                       tick_o;
  logic                       busy_o;
  state_t                     state_o;

  modport master (
    output en_i, set_i, mask_i, select_i,
    input  pulse_o, tick_o, busy_o, state_o
  );

  modport slave (
    input  en_i, set_i, mask_i, select_i,
    output pulse_o, tick_o, busy_o, state_o
  );

endinterface

// File: rtl/sweep_pwm_driver_channel.sv
// One PWM channel: active mask/select, threshold compare against the shared
// phase counter, and the registered pulse output.
module pwm_channel
  import sweep_pkg::*;
#(
  parameter int FREQ_STEPS   = 4,
  parameter int PERIOD_WIDTH = 8,
  parameter int SEL_WIDTH    = 3
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    load_mask,
  input  logic [SEL_WIDTH-1:0]    load_sel,
  input  logic [PERIOD_WIDTH-1:0] phase,
  output logic                    pulse
);

  logic                  act_mask;
  logic [SEL_WIDTH-1:0]  act_sel;
  logic [PERIOD_WIDTH:0] thr;

  always_comb begin
    thr = (PERIOD_WIDTH+1)'(threshold(int'(act_sel), FREQ_STEPS, PERIOD_WIDTH));
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      act_mask <= 1'b0;
      act_sel  <= '0;
      pulse    <= 1'b0;
    end else if (clr) begin
      act_mask <= 1'b0;
      act_sel  <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= act_mask & ({1'b0, phase} < thr);
      if (load) begin
        act_mask <= load_mask;
        act_sel  <= load_sel;
      end
    end
  end

endmodule

// File: rtl/sweep_pwm_driver.sv
// Multi-channel PWM driver paced by a prescaled phase counter; emits tick_o at
// each period end. Define SWEEP_PWM_SYNC_UPDATE_EN to defer updates to period end.
module sweep_pwm_driver
  import sweep_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int FREQ_STEPS   = 4,
  parameter int PERIOD_WIDTH = 8,
  parameter int PRESCALE     = 16
) (
  input logic              clk_i,
  input logic              arstn_i,
  sweep_pwm_driver_if.slave bus
);

  localparam int SEL_WIDTH = sel_width(FREQ_STEPS);
  localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [PRE_W-1:0]           presc;
  logic [PERIOD_WIDTH-1:0]    phase;
  logic [WIDTH-1:0]           sh_mask;
  logic [SEL_WIDTH*WIDTH-1:0] sh_sel;
  logic                       tick_q;
  logic                       clr;
  logic                       pe;
  logic                       load;
  logic                       wr_shadow;
  logic [WIDTH-1:0]           ld_mask;
  logic [SEL_WIDTH*WIDTH-1:0] ld_sel;
  logic [WIDTH-1:0]           pulse;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    pe        = 1'b0;
    load      = 1'b0;
    wr_shadow = 1'b0;

    case (state)
      ST_IDLE:  state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!bus.en_i) state_nxt = ST_IDLE;

    // Dropping enable clears everything on the same edge that enters IDLE.
    clr       = !bus.en_i || (state == ST_IDLE);
    pe        = (state == ST_RUN) && (presc == PRE_LAST) && (&phase);
    wr_shadow = bus.set_i && !clr;
`ifdef SWEEP_PWM_SYNC_UPDATE_EN
    load      = !clr && ((state == ST_START) || pe);
`else
    load      = !clr && ((state == ST_START) || bus.set_i);
`endif
  end

  // A strobe coinciding with the load point bypasses the shadow copy.
  assign ld_mask = bus.set_i ? bus.mask_i   : sh_mask;
  assign ld_sel  = bus.set_i ? bus.select_i : sh_sel;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      presc <= '0;
      phase <= '0;
    end else if (clr || (state == ST_START)) begin
      presc <= '0;
      phase <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      phase <= phase + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sh_mask <= '0;
      sh_sel  <= '0;
    end else if (clr) begin
      sh_mask <= '0;
      sh_sel  <= '0;
    end else if (wr_shadow) begin
      sh_mask <= bus.mask_i;
      sh_sel  <= bus.select_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) tick_q <= 1'b0;
    else          tick_q <= !clr && pe;
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_ch
    pwm_channel #(
      .FREQ_STEPS   (FREQ_STEPS),
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .SEL_WIDTH    (SEL_WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .arstn_i   (arstn_i),
      .clr       (clr),
      .load      (load),
      .load_mask (ld_mask[j]),
      .load_sel  (ld_sel[j*SEL_WIDTH +: SEL_WIDTH]),
      .phase     (phase),
      .pulse     (pulse[j])
    );
  end

  assign bus.pulse_o = pulse;
  assign bus.tick_o  = tick_q;
  assign bus.busy_o  = (state == ST_RUN);
  assign bus.state_o = state;

endmodule

// File: tb/tb_sweep_pwm_driver.sv
// Bench for sweep_pwm_driver: cycle-level reference model plus duty/period
// measurements over full PWM windows, directed scenarios then random traffic.
module tb_sweep_pwm_driver;

  localparam int WIDTH = 4;
  localparam int FS    = 4;
  localparam int PW    = 4;
  localparam int PS    = 2;
  localparam int SELW  = 3;
  localparam int PER   = PS * (1 << PW);

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  sweep_pwm_driver_if #(.WIDTH(WIDTH), .SEL_WIDTH(SELW)) bus ();

  sweep_pwm_driver #(
    .WIDTH(WIDTH), .FREQ_STEPS(FS), .PERIOD_WIDTH(PW), .PRESCALE(PS)
  ) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 start, 2 run. m_k counts clocks since the run began.
  logic [7:0] exp_q[$];
  int         m_mode;
  int         m_k;
  logic [3:0] m_sh_mask, m_act_mask;
  int         m_sh_sel[WIDTH];
  int         m_act_sel[WIDTH];

  function automatic int m_thr(input int sel);
    int s;
    s = (sel > FS) ? FS : sel;
    if (s == FS) return 1 << PW;
    return s * ((1 << PW) / FS);
  endfunction

  task automatic m_clear();
    m_mode = 0; m_k = 0; m_sh_mask = '0; m_act_mask = '0;
    for (int j = 0; j < WIDTH; j++) begin m_sh_sel[j] = 0; m_act_sel[j] = 0; end
  endtask

  always @(posedge clk_i or negedge arstn_i) begin
    logic [3:0] p;
    logic       t;
    int         ph;
    if (!arstn_i) begin
      m_clear();
      exp_q.delete();
    end else begin
      p = '0; t = 1'b0;
      if (!bus.en_i) begin
        m_clear();
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        ph = (m_mode == 2) ? (m_k / PS) % (1 << PW) : 0;
        for (int j = 0; j < WIDTH; j++) p[j] = m_act_mask[j] && (ph < m_thr(m_act_sel[j]));
        if (bus.set_i) begin
          m_sh_mask = bus.mask_i;
          for (int j = 0; j < WIDTH; j++) m_sh_sel[j] = int'(bus.select_i[j*SELW +: SELW]);
        end
        if (m_mode == 1) begin
          m_act_mask = m_sh_mask; m_act_sel = m_sh_sel;
          m_k = 0; m_mode = 2;
        end else begin
          t = ((m_k % PER) == PER - 1);
`ifdef SWEEP_PWM_SYNC_UPDATE_EN
          if (t) begin m_act_mask = m_sh_mask; m_act_sel = m_sh_sel; end
`else
          if (bus.set_i) begin m_act_mask = m_sh_mask; m_act_sel = m_sh_sel; end
`endif
          m_k++;
        end
      end
      exp_q.push_back({2'(m_mode), t, (m_mode == 2), p});
    end
  end

  always @(negedge clk_i) begin
    logic [7:0] e, a;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    a = {bus.state_o, bus.tick_o, bus.busy_o, bus.pulse_o};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t actual{st,tick,busy,pulse}=%b required=%b", $time, a, e);
    end
  end

  // ---------------- driver tasks ----------------
  int m_hi[WIDTH];
  int m_len;

  function automatic logic [11:0] sel4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic apply(input logic [3:0] m, input logic [11:0] s);
    bus.set_i = 1'b1; bus.mask_i = m; bus.select_i = s;
    @(negedge clk_i);
    bus.set_i = 1'b0;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * PER && !ok; i++) begin
      @(negedge clk_i);
      if (bus.tick_o) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL tick_timeout actual=no_tick required=tick t=%0t", $time);
    end
  endtask

  // Starting on a tick cycle, count high cycles per channel up to the next
  // tick; optionally strobe set_i at window index inj.
  task automatic measure(input int inj, input logic [3:0] m, input logic [11:0] s);
    for (int j = 0; j < WIDTH; j++) m_hi[j] = 0;
    m_len = 0;
    do begin
      for (int j = 0; j < WIDTH; j++) m_hi[j] += int'(bus.pulse_o[j]);
      bus.set_i = (m_len == inj);
      if (m_len == inj) begin bus.mask_i = m; bus.select_i = s; end
      m_len++;
      @(negedge clk_i);
    end while (!bus.tick_o && m_len < 4 * PER);
    bus.set_i = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int c;
    int ticks;
    bus.en_i = 1'b1; bus.set_i = 1'b0; bus.mask_i = '0; bus.select_i = '0;

    repeat (3) @(negedge clk_i);
    check("reset_pulse", int'(bus.pulse_o), 0);
    check("reset_tick",  int'(bus.tick_o),  0);
    check("reset_busy",  int'(bus.busy_o),  0);
    arstn_i = 1'b1;

    repeat (3) @(negedge clk_i);
    apply(4'b0001, sel4(4, 0, 0, 0));
    wait_tick();
    measure(-1, '0, '0);
    measure(-1, '0, '0);
    check("full_on_ch0", m_hi[0], 32);
    check("full_on_ch1_off", m_hi[1] + m_hi[2] + m_hi[3], 0);
    check("period_len", m_len, 32);

    apply(4'b0010, sel4(0, 2, 0, 0));
    wait_tick();
    measure(-1, '0, '0);
    measure(-1, '0, '0);
    check("half_ch1", m_hi[1], 16);
    check("half_ch0_masked", m_hi[0], 0);

    apply(4'b0011, sel4(7, 0, 0, 0));
    wait_tick();
    measure(-1, '0, '0);
    measure(-1, '0, '0);
    check("clamp_ch0", m_hi[0], 32);
    check("zero_ch1", m_hi[1], 0);

    apply(4'b0001, sel4(1, 0, 0, 0));
    wait_tick();
    measure(-1, '0, '0);
    measure(-1, '0, '0);
    check("quarter_ch0", m_hi[0], 8);
    measure(10, 4'b0001, sel4(3, 0, 0, 0));
`ifdef SWEEP_PWM_SYNC_UPDATE_EN
    check("sync_hold_ch0", m_hi[0], 8);
`endif
    measure(-1, '0, '0);
    check("new_duty_ch0", m_hi[0], 24);

    // Strobe on the period-end cycle (window index 31).
    measure(31, 4'b0001, sel4(2, 0, 0, 0));
    check("pe_set_old_window", m_hi[0], 24);
    measure(-1, '0, '0);
    check("pe_set_new_window", m_hi[0], 16);

    // Now on a tick cycle (phase 0); index 10 is phase 5.
    repeat (10) @(negedge clk_i);
    check("pre_drop_pulse", int'(bus.pulse_o[0]), 1);
    bus.en_i = 1'b0;
    @(negedge clk_i);
    check("drop_pulse", int'(bus.pulse_o), 0);
    check("drop_busy",  int'(bus.busy_o),  0);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      ticks += int'(bus.tick_o);
    end
    check("drop_no_tick", ticks, 0);

    bus.en_i = 1'b1;
    c = 0;
    while (bus.state_o != 2'b01 && c < 10) begin @(negedge clk_i); c++; end
    check("reenable_start_seen", int'(c < 10), 1);
    // Period covers the 32 clocks after START; the registered tick follows.
    c = 0;
    do begin @(negedge clk_i); c++; end while (!bus.tick_o && c < 4 * PER);
    check("reenable_first_tick", c, 33);

    for (int i = 0; i < 600; i++) begin
      bus.en_i     = ($urandom_range(0, 79) != 0);
      bus.set_i    = ($urandom_range(0, 7) == 0);
      bus.mask_i   = 4'($urandom_range(0, 15));
      bus.select_i = 12'($urandom_range(0, 4095));
      @(negedge clk_i);
    end
    bus.set_i = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
